tread_input_mapper: RTL

- Parametrised successor to the single-pair joystick-to-tread converter used in the Ultra Tank top level.
- Merges PS/2 key events and per-player USB/DB9 joystick words for PLAYERS players.
- Per player: debounces the merged 8-way direction, holds diagonals briefly to suppress cardinal glitches on release, and maps the result to left/right tread forward/back levels.
- Sits between hps_io/joy_db9md and the game core; all outputs are active-high registered levels, and the top level inverts them for the core.

---
 rtl/tread_input_mapper.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/tread_input_mapper.sv
// Merges PS/2 keys and per-player joysticks, debounces each 8-way
// direction, holds decaying diagonals and drives tread levels.
module tread_input_mapper #(
  parameter int PLAYERS   = 2,
  parameter int DEBOUNCE  = 16,
  parameter int DIAG_HOLD = 4096
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic [PLAYERS*8-1:0] joy_in,
  input  logic [PLAYERS-1:0]   reverse_steer,
  output logic [PLAYERS-1:0]   tread_l_fw,
  output logic [PLAYERS-1:0]   tread_l_bk,
  output logic [PLAYERS-1:0]   tread_r_fw,
  output logic [PLAYERS-1:0]   tread_r_bk,
  output logic [PLAYERS-1:0]   fire,
  output logic                 start1,
  output logic                 start2,
  output logic                 coin
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int TW = (DIAG_HOLD > 1) ? $clog2(DIAG_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
  localparam logic [TW-1:0] TMR_MAX = TW'(DIAG_HOLD - 1);

  typedef enum logic {TRACK, HOLD} hold_e;

  function automatic logic is_diag(input logic [3:0] d);
    return (d[3] ^ d[2]) & (d[1] ^ d[0]);
  endfunction

  function automatic logic is_card_of(input logic [3:0] c,
                                      input logic [3:0] d);
    return (c != 4'd0) && ((c & (c - 4'd1)) == 4'd0)
           && ((c & d) == c);
  endfunction

  // eff = {up,down,left,right} -> {l_fw,l_bk,r_fw,r_bk}
  function automatic logic [3:0] tread_map(input logic [3:0] d,
                                           input logic       rs);
    logic [3:0] m;
    case (d)
      4'b1000: m = 4'b1010;
      4'b1010: m = 4'b0010;
      4'b1001: m = 4'b1000;
      4'b0001: m = 4'b1001;
      4'b0010: m = 4'b0110;
      4'b0100: m = 4'b0101;
      4'b0101: m = rs ? 4'b0001 : 4'b0100;
      4'b0110: m = rs ? 4'b0100 : 4'b0001;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  logic       tog_q;
  logic [3:0] kdir [4];
  logic [3:0] kfire;
  logic       ks1;
  logic       ks2;
  logic       kcoin;
  logic       ps2_ev;
  logic       press;
  logic [8:0] code;

  assign ps2_ev = ps2_key[10] ^ tog_q;
  assign press  = ps2_key[9];
  assign code   = ps2_key[8:0];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tog_q <= 1'b0;
      kdir  <= '{default: 4'd0};
      kfire <= 4'd0;
      ks1   <= 1'b0;
      ks2   <= 1'b0;
      kcoin <= 1'b0;
    end else begin
      tog_q <= ps2_key[10];
      if (ps2_ev) begin
        // arrows accept both plain and extended codes
        case (code[7:0])
          8'h75:   kdir[0][3] <= press;
          8'h72:   kdir[0][2] <= press;
          8'h6B:   kdir[0][1] <= press;
          8'h74:   kdir[0][0] <= press;
          default: ;
        endcase
        if (!code[8]) begin
          case (code[7:0])
            8'h14:   kfire[0]   <= press;
            8'h2D:   kdir[1][3] <= press;
            8'h2B:   kdir[1][2] <= press;
            8'h23:   kdir[1][1] <= press;
            8'h34:   kdir[1][0] <= press;
            8'h1C:   kfire[1]   <= press;
            8'h16,
            8'h05:   ks1        <= press;
            8'h1E,
            8'h06:   ks2        <= press;
            8'h2E,
            8'h36,
            8'h04:   kcoin      <= press;
            default: ;
          endcase
        end
      end
    end
  end

  logic s1_raw;
  logic s2_raw;
  logic coin_raw;

  always_comb begin
    s1_raw   = ks1;
    s2_raw   = ks2;
    coin_raw = kcoin;
    for (int p = 0; p < PLAYERS; p++) begin
      s1_raw   = s1_raw   | joy_in[p*8+5];
      s2_raw   = s2_raw   | joy_in[p*8+6];
      coin_raw = coin_raw | joy_in[p*8+7];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      start1 <= 1'b0;
      start2 <= 1'b0;
      coin   <= 1'b0;
    end else begin
      start1 <= s1_raw;
      start2 <= s2_raw;
      coin   <= coin_raw;
    end
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [3:0]    raw;
    logic [3:0]    smp;
    logic [3:0]    stb;
    logic [3:0]    prv;
    logic [3:0]    held;
    logic [3:0]    held_n;
    logic [3:0]    eff;
    logic [3:0]    trd;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_n;
    hold_e         st;
    hold_e         st_n;
    logic          fire_q;

    assign raw = kdir[p] | joy_in[p*8 +: 4];

    always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
        smp    <= 4'd0;
        cnt    <= '0;
        stb    <= 4'd0;
        prv    <= 4'd0;
        st     <= TRACK;
        held   <= 4'd0;
        tmr    <= '0;
        trd    <= 4'd0;
        fire_q <= 1'b0;
      end else begin
        smp <= raw;
        if (raw != smp) begin
          cnt <= '0;
        end else if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
        if (cnt == CNT_MAX && smp != stb) begin
          stb <= smp;
        end
        prv    <= stb;
        st     <= st_n;
        held   <= held_n;
        tmr    <= tmr_n;
        trd    <= tread_map(eff, reverse_steer[p]);
        fire_q <= kfire[p] | joy_in[p*8+4];
      end
    end

    // prv differs from stb only in the cycle right after a change
    always_comb begin
      st_n   = st;
      held_n = held;
      tmr_n  = tmr;
      eff    = stb;
      unique case (st)
        TRACK: begin
          if (is_diag(prv) && is_card_of(stb, prv)) begin
            st_n   = HOLD;
            held_n = prv;
            tmr_n  = TMR_MAX;
            eff    = prv;
          end
        end
        HOLD: begin
          if (stb == held) begin
            st_n = TRACK;
            eff  = held;
          end else if (stb != prv || tmr == '0) begin
            st_n = TRACK;
          end else begin
            tmr_n = tmr - 1'b1;
            eff   = held;
          end
        end
        default: st_n = TRACK;
      endcase
    end

    assign tread_l_fw[p] = trd[3];
    assign tread_l_bk[p] = trd[2];
    assign tread_r_fw[p] = trd[1];
    assign tread_r_bk[p] = trd[0];
    assign fire[p]       = fire_q;
  end

endmodule
